// File: rtl/ff_d_regfile_if.sv
// rtl/ff_d_regfile_if.sv - write/read/clear bundle for the flip-flop register file
interface ff_d_regfile_if #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 5,
    parameter int RD_PORTS = 2
);
    localparam int STRB = (DATA_LEN + 7) / 8;

    logic                         wen;
    logic [ADDR_LEN-1:0]          waddr;
    logic [DATA_LEN-1:0]          wdata;
    logic [STRB-1:0]              wstrb;
    logic [RD_PORTS*ADDR_LEN-1:0] raddr;
    logic [RD_PORTS*DATA_LEN-1:0] rdata;
    logic                         clr_req;
    logic                         clr_busy;

    modport master (
        output wen, waddr, wdata, wstrb, raddr, clr_req,
        input  rdata, clr_busy
    );

    modport slave (
        input  wen, waddr, wdata, wstrb, raddr, clr_req,
        output rdata, clr_busy
    );
endinterface

// File: rtl/ff_d_regfile.sv
// rtl/ff_d_regfile.sv - multi-read-port FF register file with strobes, bypass, bulk clear; FF_D_REGFILE_RDREG_EN registers rdata
module ff_d_regfile #(
    parameter int                  DATA_LEN = 32,
    parameter int                  ADDR_LEN = 5,
    parameter int                  RD_PORTS = 2,
    parameter logic [DATA_LEN-1:0] RST_DATA = '0,
    parameter bit                  BYPASS   = 1'b0,
    parameter bit                  ZERO_REG = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    ff_d_regfile_if.slave bus
);
    localparam int              DEPTH    = 1 << ADDR_LEN;
    localparam logic [ADDR_LEN:0] PTR_LAST = (ADDR_LEN+1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_LEN:0]   ptr, ptr_nxt;
    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [DATA_LEN-1:0] wmask;
    logic                wr_ok;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < DATA_LEN; i++) wmask[i] = bus.wstrb[i/8];
    end

    // Entry 0 is never written when hardwired, so the bypass path below also skips it.
    assign wr_ok = bus.wen && (state == IDLE) && !(ZERO_REG && (bus.waddr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_DATA;
        end else if (state == CLEAR) begin
            mem[ptr[ADDR_LEN-1:0]] <= RST_DATA;
        end else if (wr_ok) begin
            mem[bus.waddr] <= (mem[bus.waddr] & ~wmask) | (bus.wdata & wmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                ptr_nxt = '0;
                if (bus.clr_req) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (ptr == PTR_LAST) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.clr_busy = (state == CLEAR);

    wire [RD_PORTS*DATA_LEN-1:0] rd_comb;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        wire [ADDR_LEN-1:0] ra  = bus.raddr[p*ADDR_LEN +: ADDR_LEN];
        wire [DATA_LEN-1:0] old = mem[ra];
        wire                hit = BYPASS && wr_ok && (bus.waddr == ra);
        assign rd_comb[p*DATA_LEN +: DATA_LEN] =
            (ZERO_REG && (ra == '0)) ? RST_DATA :
            hit                      ? ((old & ~wmask) | (bus.wdata & wmask)) :
                                       old;
    end

`ifdef FF_D_REGFILE_RDREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rdata <= {RD_PORTS{RST_DATA}};
        else        bus.rdata <= rd_comb;
    end
`else
    assign bus.rdata = rd_comb;
`endif
endmodule
